m68k_bus_initiator: RTL and testbench
=====================================

# m68k_bus_initiator

Bus master that runs 68000-style asynchronous bus cycles (AS/UDS/LDS/R-W, data transfer closed by DTACK) on behalf of an on-chip requester such as a DMA or blitter engine. It is the initiator end of the DTACK handshake: it strobes the shared 68k bus, waits for the system DTACK, returns read data, and releases the bus. A timeout converts a missing DTACK into a bus error so the requester never hangs.

## Interface
- TIMEOUT_CYCLES, 255: maximum strobe or recovery wait in clocks; 0 disables the timeout.
- Clk  in  1  system clock; all state changes on the rising edge.
- Reset_L  in  1  asynchronous, active-low reset.
- Req_H  in  1  transfer request; accepted only on an edge where Busy_H=0.
- ReqRW_H  in  1  1=read, 0=write; latched on accept.
- ReqAddr  in  32  byte address; latched on accept; bit 0 ignored.
- ReqByteEn  in  2  [1]=upper byte (UDS), [0]=lower byte (LDS); 2'b00 is treated as 2'b11.
- ReqWData  in  16  write data; latched on accept.
- Ack_H  out  1  one-cycle pulse at transfer completion, including on error.
- BusErr_H  out  1  one-cycle pulse, coincident with Ack_H, when the strobe phase timed out.
- RData  out  16  read data; valid from Ack_H until the next Ack_H.
- Busy_H  out  1  high in every state except IDLE.
- AS_L, UDS_L, LDS_L  out  1 each  bus strobes, active low.
- RW  out  1  bus direction, 1=read.
- Addr  out  32  bus address, bit 0 always 0.
- DataOut  out  16  write data to the bus.
- DataOutEn_H  out  1  tri-state enable for DataOut.
- DataIn  in  16  read data from the bus.
- DtackIn_L  in  1  system DTACK, active low, sampled on Clk with no synchronizer (same clock domain).

## Operation
- States: IDLE, ADDR, STROBE, RECOVER.
- IDLE: all strobes high, DataOutEn_H=0. On Req_H=1, latch the request, clear the wait counter, and go to ADDR.
- ADDR (1 cycle): drive Addr, RW, and for writes DataOut with DataOutEn_H=1. AS_L and DS stay high (address setup). Go to STROBE.
- STROBE:
  - AS_L=0. UDS_L = ~ByteEn[1] and LDS_L = ~ByteEn[0], asserted in the same cycle as AS_L for both reads and writes.
  - On an edge with DtackIn_L=0: capture DataIn into RData on reads (writes leave RData unchanged), pulse Ack_H, go to RECOVER.
  - Otherwise increment the counter. When the counter reaches TIMEOUT_CYCLES (non-zero), pulse Ack_H and BusErr_H, load RData=16'hFFFF, go to RECOVER.
- RECOVER: AS_L, UDS_L, LDS_L = 1; DataOutEn_H=0; Addr and RW hold their values. Go to IDLE on the first edge with DtackIn_L=1. If DtackIn_L stays low for TIMEOUT_CYCLES (non-zero), go to IDLE anyway with no further pulse. The counter is cleared on entry to RECOVER.
- Counter width: clog2(TIMEOUT_CYCLES+1); it saturates and never wraps.
- Req_H while Busy_H=1 is ignored and does not queue. The requester holds Req_H until it sees Ack_H, or re-asserts it.

## Timing
- Reset values: AS_L=UDS_L=LDS_L=1, RW=1, Addr=0, DataOut=0, DataOutEn_H=0, Ack_H=0, BusErr_H=0, RData=0, Busy_H=0, state=IDLE, counter=0.
- Reset asserted mid-cycle forces all strobes high immediately (asynchronous). No Ack_H is produced for the aborted transfer.
- Zero-wait cycle, with Req_H accepted at edge k:
  - ADDR during k..k+1.
  - STROBE during k+1..k+2.
  - DTACK sampled low at k+2, giving Ack_H during k+2..k+3.
  - RECOVER ends at k+3 if DTACK has returned high.
  - Busy_H falls after k+3; the next accept is at k+4. Minimum period is 4 clocks.
- Each clock of DTACK delay adds exactly one STROBE cycle.
- Timeout: with DTACK never asserted, Ack_H/BusErr_H are high during cycle k+1+TIMEOUT_CYCLES.
- Ack_H and BusErr_H are never high for more than one cycle. BusErr_H never appears without Ack_H.

## Test plan
- Zero-wait read: DTACK low whenever AS_L=0, DataIn=16'h1234, Req at addr 32'h0000_0102, byte enables 11 -> AS_L low for exactly 1 cycle, Addr=32'h0000_0102, Ack_H one pulse 2 cycles after accept, RData=16'h1234, BusErr_H=0.
- Waited write: DTACK delayed 5 cycles after AS_L falls, byte enables 10, data 16'hBEEF -> UDS_L=0, LDS_L=1, RW=0, DataOutEn_H=1 from ADDR through STROBE, DataOut=16'hBEEF, Ack_H exactly 5 cycles after AS_L falls.
- Timeout: TIMEOUT_CYCLES=8, DTACK held high -> Ack_H and BusErr_H together after 8 strobe cycles, RData=16'hFFFF, strobes negated the next cycle, Busy_H drops one cycle later.
- Slow DTACK release: DTACK stays low 3 cycles after AS_L rises -> state remains RECOVER for 3 cycles, no second Ack_H, a Req held high is accepted only after the release.
- Reset mid-STROBE: Reset_L pulsed low while AS_L=0 -> AS_L/UDS_L/LDS_L high asynchronously, all outputs at reset values, no Ack_H. A new read after reset completes normally.
- Back-to-back: Req_H held high for 3 zero-wait reads -> accepts spaced exactly 4 clocks apart, 3 Ack_H pulses.

Source files
------------

// File: rtl/m68k_bus_initiator.sv
// 68000-style bus initiator: runs one AS/UDS/LDS cycle per accepted request,
// closes it on DTACK, and turns a missing DTACK into a bus error.
module m68k_bus_initiator #(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic        Clk,
  input  logic        Reset_L,
  input  logic        Req_H,
  input  logic        ReqRW_H,
  input  logic [31:0] ReqAddr,
  input  logic [1:0]  ReqByteEn,
  input  logic [15:0] ReqWData,
  output logic        Ack_H,
  output logic        BusErr_H,
  output logic [15:0] RData,
  output logic        Busy_H,
  output logic        AS_L,
  output logic        UDS_L,
  output logic        LDS_L,
  output logic        RW,
  output logic [31:0] Addr,
  output logic [15:0] DataOut,
  output logic        DataOutEn_H,
  input  logic [15:0] DataIn,
  input  logic        DtackIn_L
);

  // Counter needs to hold TIMEOUT_CYCLES; keep at least one bit when disabled.
  localparam int CW = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam int LIMIT_I = (TIMEOUT_CYCLES > 0) ? int'(TIMEOUT_CYCLES) - 1 : 0;
  localparam logic [CW-1:0] LIMIT   = CW'(LIMIT_I);
  localparam logic [CW-1:0] CNT_MAX = '1;
  localparam bit TIMEOUT_EN = (TIMEOUT_CYCLES > 0);

  typedef enum logic [1:0] {IDLE, ADDR, STROBE, RECOVER} state_t;

  state_t         state_reg, state_next;
  logic [CW-1:0]  cnt_reg, cnt_next, cnt_inc;
  logic           rw_reg;
  logic [31:0]    addr_reg;
  logic [1:0]     be_reg;
  logic [15:0]    wdata_reg;
  logic [15:0]    rdata_reg, rdata_next;
  logic           ack_reg, ack_next;
  logic           err_reg, err_next;
  logic           accept;
  logic           limit_hit;

  // Saturating increment; the wait counter must never wrap back to zero.
  assign cnt_inc   = (cnt_reg == CNT_MAX) ? cnt_reg : cnt_reg + 1'b1;
  // This edge is the TIMEOUT_CYCLES-th consecutive wait edge of the phase.
  assign limit_hit = TIMEOUT_EN && (cnt_reg == LIMIT);

  // Next-state, wait counter and completion pulses.
  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    rdata_next = rdata_reg;
    ack_next   = 1'b0;
    err_next   = 1'b0;
    accept     = 1'b0;
    case (state_reg)
      IDLE: begin
        if (Req_H) begin
          accept     = 1'b1;
          cnt_next   = '0;
          state_next = ADDR;
        end
      end
      ADDR: state_next = STROBE;
      STROBE: begin
        if (!DtackIn_L) begin
          // DTACK wins over a timeout landing on the same edge.
          if (rw_reg) rdata_next = DataIn;
          ack_next   = 1'b1;
          cnt_next   = '0;
          state_next = RECOVER;
        end else if (limit_hit) begin
          ack_next   = 1'b1;
          err_next   = 1'b1;
          rdata_next = 16'hFFFF;
          cnt_next   = '0;
          state_next = RECOVER;
        end else begin
          cnt_next = cnt_inc;
        end
      end
      RECOVER: begin
        // Wait for the target to drop DTACK, but never forever.
        if (DtackIn_L || limit_hit) begin
          cnt_next   = '0;
          state_next = IDLE;
        end else begin
          cnt_next = cnt_inc;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // State, request latches and result registers.
  always_ff @(posedge Clk or negedge Reset_L) begin
    if (!Reset_L) begin
      state_reg <= IDLE;
      cnt_reg   <= '0;
      rw_reg    <= 1'b1;
      addr_reg  <= '0;
      be_reg    <= 2'b00;
      wdata_reg <= '0;
      rdata_reg <= '0;
      ack_reg   <= 1'b0;
      err_reg   <= 1'b0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
      rdata_reg <= rdata_next;
      ack_reg   <= ack_next;
      err_reg   <= err_next;
      if (accept) begin
        rw_reg    <= ReqRW_H;
        addr_reg  <= ReqAddr & ~32'h1;
        be_reg    <= (ReqByteEn == 2'b00) ? 2'b11 : ReqByteEn;
        wdata_reg <= ReqWData;
      end
    end
  end

  // Bus pins decode straight from the state register so reset clears them at once.
  assign Busy_H      = (state_reg != IDLE);
  assign AS_L        = (state_reg != STROBE);
  assign UDS_L       = !((state_reg == STROBE) && be_reg[1]);
  assign LDS_L       = !((state_reg == STROBE) && be_reg[0]);
  assign DataOutEn_H = !rw_reg && ((state_reg == ADDR) || (state_reg == STROBE));
  assign RW          = rw_reg;
  assign Addr        = addr_reg;
  assign DataOut     = wdata_reg;
  assign RData       = rdata_reg;
  assign Ack_H       = ack_reg;
  assign BusErr_H    = err_reg;

endmodule

// File: tb/tb_m68k_bus_initiator.sv
// Bench for m68k_bus_initiator: vector table, hand-written corner sequences,
// and randomized transfers against a timing/data reference model.
module tb_m68k_bus_initiator;

  localparam int T = 8;

  logic        Clk = 1'b0;
  logic        Reset_L;
  logic        Req_H;
  logic        ReqRW_H;
  logic [31:0] ReqAddr;
  logic [1:0]  ReqByteEn;
  logic [15:0] ReqWData;
  logic        Ack_H;
  logic        BusErr_H;
  logic [15:0] RData;
  logic        Busy_H;
  logic        AS_L;
  logic        UDS_L;
  logic        LDS_L;
  logic        RW;
  logic [31:0] Addr;
  logic [15:0] DataOut;
  logic        DataOutEn_H;
  logic [15:0] DataIn;
  logic        DtackIn_L;

  m68k_bus_initiator #(.TIMEOUT_CYCLES(T)) dut (
    .Clk(Clk), .Reset_L(Reset_L), .Req_H(Req_H), .ReqRW_H(ReqRW_H),
    .ReqAddr(ReqAddr), .ReqByteEn(ReqByteEn), .ReqWData(ReqWData),
    .Ack_H(Ack_H), .BusErr_H(BusErr_H), .RData(RData), .Busy_H(Busy_H),
    .AS_L(AS_L), .UDS_L(UDS_L), .LDS_L(LDS_L), .RW(RW), .Addr(Addr),
    .DataOut(DataOut), .DataOutEn_H(DataOutEn_H), .DataIn(DataIn),
    .DtackIn_L(DtackIn_L)
  );

  // Clock generator.
  always #5 Clk = ~Clk;

  int tests = 0;
  int fails = 0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  // Target model: DTACK low from the dtack_wait-th strobe cycle, held for
  // dtack_release cycles after AS_L rises.
  int dtack_wait = 1;
  int dtack_release = 0;
  int as_cycles = 0;
  int hold_cnt = 0;
  always @(negedge Clk) begin
    if (!Reset_L) begin
      DtackIn_L = 1'b1; as_cycles = 0; hold_cnt = 0;
    end else if (!AS_L) begin
      as_cycles++;
      hold_cnt = 0;
      DtackIn_L = !(as_cycles >= dtack_wait);
    end else begin
      as_cycles = 0;
      if (!DtackIn_L && hold_cnt < dtack_release) hold_cnt++;
      else DtackIn_L = 1'b1;
    end
  end

  typedef struct {
    logic        rw;
    logic [31:0] addr;
    logic [1:0]  be;
    logic [15:0] wd;
    logic [15:0] din;
    int          w;
    int          r;
    logic [15:0] exp_rdata;
    logic        exp_err;
    int          exp_lat;
    int          exp_done;
    logic        exp_uds;
    logic        exp_lds;
  } vec_t;

  vec_t vecs[7];

  // Drive one request, observe it until Busy_H drops, and compare.
  task automatic apply_and_check(input vec_t v, input string tag);
    int ack_cnt, ack_n, err_seen, orphan, as_low, done_n;
    logic [15:0] rd_at_ack;
    logic [31:0] a0, exp_addr;
    logic rw0, den0, as0, busy0, st_uds, st_lds, st_den;
    logic [15:0] st_dout;
    ack_cnt = 0; ack_n = -1; err_seen = 0; orphan = 0; as_low = 0; done_n = -1;
    rd_at_ack = 16'h0; a0 = '0; rw0 = 0; den0 = 0; as0 = 0; busy0 = 0;
    st_uds = 1; st_lds = 1; st_den = 0; st_dout = 16'h0;
    dtack_wait = v.w; dtack_release = v.r; DataIn = v.din;
    @(negedge Clk);
    Req_H = 1'b1; ReqRW_H = v.rw; ReqAddr = v.addr; ReqByteEn = v.be; ReqWData = v.wd;
    for (int n = 0; n < 200; n++) begin
      @(negedge Clk);
      if (n == 0) begin
        Req_H = 1'b0;
        a0 = Addr; rw0 = RW; den0 = DataOutEn_H; as0 = AS_L; busy0 = Busy_H;
      end
      if (!AS_L) begin
        as_low++; st_uds = UDS_L; st_lds = LDS_L; st_den = DataOutEn_H; st_dout = DataOut;
      end
      if (Ack_H) begin
        ack_cnt++; ack_n = n; rd_at_ack = RData; err_seen = int'(BusErr_H);
      end
      if (BusErr_H && !Ack_H) orphan++;
      if (!Busy_H) begin done_n = n; break; end
    end
    exp_addr = v.addr; exp_addr[0] = 1'b0;
    check({tag, " busy_addr"}, {31'd0, busy0}, 32'd1);
    check({tag, " as_in_addr"}, {31'd0, as0}, 32'd1);
    check({tag, " addr"}, a0, exp_addr);
    check({tag, " rw"}, {31'd0, rw0}, {31'd0, v.rw});
    check({tag, " den_addr"}, {31'd0, den0}, {31'd0, !v.rw});
    check({tag, " ack_count"}, ack_cnt, 32'd1);
    check({tag, " ack_latency"}, ack_n, v.exp_lat);
    check({tag, " buserr"}, err_seen, {31'd0, v.exp_err});
    check({tag, " orphan_err"}, orphan, 32'd0);
    check({tag, " rdata"}, {16'd0, rd_at_ack}, {16'd0, v.exp_rdata});
    check({tag, " as_low_cycles"}, as_low, v.exp_lat - 1);
    check({tag, " uds"}, {31'd0, st_uds}, {31'd0, v.exp_uds});
    check({tag, " lds"}, {31'd0, st_lds}, {31'd0, v.exp_lds});
    check({tag, " den_strobe"}, {31'd0, st_den}, {31'd0, !v.rw});
    if (!v.rw) check({tag, " dataout"}, {16'd0, st_dout}, {16'd0, v.wd});
    check({tag, " busy_done"}, done_n, v.exp_done);
    $display("[TB] %s rw=%0d addr=%08h be=%b ack@%0d err=%0d rdata=%04h done@%0d",
             tag, v.rw, v.addr, v.be, ack_n, err_seen, rd_at_ack, done_n);
  endtask

  logic [15:0] prev_rdata;
  int rise_idx[4];
  int ack_idx[4];

  initial begin
    vec_t rv;
    int rises, acks;
    logic prev_busy;
    logic [1:0] be_eff;

    //        rw    addr          be     wd        din       w     r  rdata     err   lat done uds   lds
    vecs[0] = '{1'b1, 32'h0000_0102, 2'b11, 16'h0000, 16'h1234, 1,    0, 16'h1234, 1'b0, 2,  3,  1'b0, 1'b0};
    vecs[1] = '{1'b0, 32'h0000_2000, 2'b10, 16'hBEEF, 16'h0000, 5,    0, 16'h1234, 1'b0, 6,  7,  1'b0, 1'b1};
    vecs[2] = '{1'b1, 32'h0000_3000, 2'b11, 16'h0000, 16'h9999, 1000, 0, 16'hFFFF, 1'b1, 9,  10, 1'b0, 1'b0};
    vecs[3] = '{1'b1, 32'h0000_1235, 2'b00, 16'h0000, 16'hA5A5, 3,    2, 16'hA5A5, 1'b0, 4,  7,  1'b0, 1'b0};
    vecs[4] = '{1'b1, 32'hFFFF_FFFE, 2'b01, 16'h0000, 16'h5555, 8,    0, 16'h5555, 1'b0, 9,  10, 1'b1, 1'b0};
    vecs[5] = '{1'b0, 32'h8000_0010, 2'b01, 16'h1357, 16'h0000, 2,    7, 16'h5555, 1'b0, 3,  11, 1'b1, 1'b0};
    vecs[6] = '{1'b1, 32'h0000_0040, 2'b11, 16'h0000, 16'h0F0F, 1,    8, 16'h0F0F, 1'b0, 2,  10, 1'b0, 1'b0};

    Reset_L = 1'b0; Req_H = 1'b0; ReqRW_H = 1'b0; ReqAddr = '0; ReqByteEn = 2'b00;
    ReqWData = '0; DataIn = '0; DtackIn_L = 1'b1;
    repeat (3) @(posedge Clk);
    @(negedge Clk);
    check("reset AS_L", {31'd0, AS_L}, 32'd1);
    check("reset UDS_L/LDS_L", {30'd0, UDS_L, LDS_L}, 32'd3);
    check("reset RW", {31'd0, RW}, 32'd1);
    check("reset Addr", Addr, 32'd0);
    check("reset DataOut", {16'd0, DataOut}, 32'd0);
    check("reset RData", {16'd0, RData}, 32'd0);
    check("reset Ack/Err/Busy/Den", {28'd0, Ack_H, BusErr_H, Busy_H, DataOutEn_H}, 32'd0);
    Reset_L = 1'b1;

    // Vector table.
    for (int i = 0; i < 7; i++) apply_and_check(vecs[i], $sformatf("vec%0d", i));
    prev_rdata = 16'h0F0F;

    // Back-to-back: Req_H held for three zero-wait reads.
    dtack_wait = 1; dtack_release = 0; DataIn = 16'hC0DE;
    @(negedge Clk);
    Req_H = 1'b1; ReqRW_H = 1'b1; ReqAddr = 32'h100; ReqByteEn = 2'b11;
    rises = 0; acks = 0; prev_busy = 1'b0;
    for (int j = 0; j < 12; j++) begin
      @(negedge Clk);
      if (Busy_H && !prev_busy && rises < 4) begin rise_idx[rises] = j; rises++; end
      if (Ack_H && acks < 4) begin ack_idx[acks] = j; acks++; end
      prev_busy = Busy_H;
      if (j == 11) Req_H = 1'b0;
    end
    @(negedge Clk);
    check("b2b accepts", rises, 32'd3);
    check("b2b acks", acks, 32'd3);
    check("b2b spacing1", rise_idx[1] - rise_idx[0], 32'd4);
    check("b2b spacing2", rise_idx[2] - rise_idx[1], 32'd4);
    check("b2b idle after", {31'd0, Busy_H}, 32'd0);
    check("b2b rdata", {16'd0, RData}, 32'h0000_C0DE);
    $display("[TB] back-to-back accepts=%0d acks=%0d", rises, acks);

    // Slow DTACK release with Req_H held: second accept only after release.
    dtack_wait = 1; dtack_release = 3; DataIn = 16'h7777;
    @(negedge Clk);
    Req_H = 1'b1; ReqAddr = 32'h200;
    rises = 0; acks = 0; prev_busy = 1'b0;
    rise_idx = '{-1, -1, -1, -1}; ack_idx = '{-1, -1, -1, -1};
    for (int j = 0; j < 16; j++) begin
      @(negedge Clk);
      if (Busy_H && !prev_busy && rises < 4) begin rise_idx[rises] = j; rises++; end
      if (Ack_H && acks < 4) begin ack_idx[acks] = j; acks++; end
      prev_busy = Busy_H;
      if (j == 7) Req_H = 1'b0;
    end
    check("slow accepts", rises, 32'd2);
    check("slow re-accept", rise_idx[1], 32'd7);
    check("slow acks", acks, 32'd2);
    check("slow ack1", ack_idx[0], 32'd2);
    check("slow ack2", ack_idx[1], 32'd9);
    check("slow idle after", {31'd0, Busy_H}, 32'd0);
    $display("[TB] slow release accepts@%0d,%0d acks@%0d,%0d",
             rise_idx[0], rise_idx[1], ack_idx[0], ack_idx[1]);
    prev_rdata = 16'h7777;

    // Randomized transfers against the reference model.
    for (int i = 0; i < 24; i++) begin
      rv.rw = 1'($urandom_range(0, 1));
      rv.addr = $urandom;
      rv.be = 2'($urandom_range(0, 3));
      rv.wd = 16'($urandom);
      rv.din = 16'($urandom);
      rv.w = int'($urandom_range(1, 11));
      rv.r = int'($urandom_range(0, 8));
      rv.exp_err = (rv.w > T);
      rv.exp_lat = 1 + (rv.exp_err ? T : rv.w);
      begin
        int low_recover;
        low_recover = rv.exp_err ? 0 : rv.r;
        rv.exp_done = rv.exp_lat + ((low_recover < T) ? low_recover + 1 : T);
      end
      rv.exp_rdata = rv.exp_err ? 16'hFFFF : (rv.rw ? rv.din : prev_rdata);
      prev_rdata = rv.exp_rdata;
      be_eff = (rv.be == 2'b00) ? 2'b11 : rv.be;
      rv.exp_uds = !be_eff[1];
      rv.exp_lds = !be_eff[0];
      apply_and_check(rv, $sformatf("rnd%0d", i));
    end

    // Reset pulsed mid-STROBE.
    dtack_wait = 1000; dtack_release = 0;
    @(negedge Clk);
    Req_H = 1'b1; ReqRW_H = 1'b0; ReqAddr = 32'h400; ReqByteEn = 2'b11; ReqWData = 16'hAAAA;
    @(negedge Clk);
    Req_H = 1'b0;
    @(negedge Clk);
    @(negedge Clk);
    check("rst pre AS_L", {31'd0, AS_L}, 32'd0);
    Reset_L = 1'b0;
    #1;
    check("rst async strobes", {29'd0, AS_L, UDS_L, LDS_L}, 32'd7);
    check("rst async Busy/Ack/Err/Den", {28'd0, Busy_H, Ack_H, BusErr_H, DataOutEn_H}, 32'd0);
    check("rst async RW", {31'd0, RW}, 32'd1);
    check("rst async Addr", Addr, 32'd0);
    check("rst async RData", {16'd0, RData}, 32'd0);
    check("rst async DataOut", {16'd0, DataOut}, 32'd0);
    @(posedge Clk);
    @(negedge Clk);
    Reset_L = 1'b1;
    acks = 0;
    for (int j = 0; j < 3; j++) begin
      @(negedge Clk);
      if (Ack_H) acks++;
    end
    check("rst no ack", acks, 32'd0);
    $display("[TB] reset mid-strobe acks_after=%0d", acks);
    rv = '{1'b1, 32'h0000_0080, 2'b11, 16'h0000, 16'h4321, 1, 0, 16'h4321, 1'b0, 2, 3, 1'b0, 1'b0};
    apply_and_check(rv, "post_reset");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
